decoder_seq_nx2n: RTL

Registered, parametrised N-to-NUM_OUT one-hot decoder with valid/ready input handshake and an autonomous scan mode. It drives one-hot select lines (channel enables, chip selects, mux selects) from a control FSM. Outputs are held between updates, and scan sequencing walks the active line automatically at a fixed dwell rate.

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_dwell_timer.sv | 30 +++
 rtl/decoder_seq_nx2n.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder_seq_nx2n one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int unsigned ONEHOT_MAX_W = 256;

    // Callers narrow the result with a size cast to their own NUM_OUT.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx);
        return ONEHOT_MAX_W'(1) << idx;
    endfunction

    // Dwell counter width: $clog2(DWELL), never narrower than one bit.
    function automatic int unsigned dwell_w(input int unsigned dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/decoder_dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while running, ticks on the last count.
module decoder_dwell_timer #(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned DWELL_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_tick
);

    logic [DWELL_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == DWELL_W'(DWELL - 1));
    assign o_tick = i_run && w_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= w_last ? '0 : r_cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-NUM_OUT one-hot decoder with valid/ready input and autonomous scan mode.
// Optional feature macro: DECODER_SEQ_RANGE_ERR_EN (out-of-range index flags range_err, state kept).
module decoder_seq_nx2n
    import decoder_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned NUM_OUT = 2**N,
    parameter int unsigned DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_idx,
    input  logic               scan_en,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic               scan_wrap,
    output logic               range_err
);

    localparam int unsigned DWELL_W = dwell_w(DWELL);

    state_t             r_state,     w_state_next;
    logic [N-1:0]       r_cur_idx,   w_cur_idx_next;
    logic [NUM_OUT-1:0] r_y,         w_y_next;
    logic               r_y_valid,   w_y_valid_next;
    logic               r_scan_wrap, w_scan_wrap_next;
`ifdef DECODER_SEQ_RANGE_ERR_EN
    logic               r_range_err, w_range_err_next;
`endif

    logic         w_in_range;
    logic         w_at_last;
    logic [N-1:0] w_idx_adv;
    logic         w_timer_load;
    logic         w_timer_run;
    logic         w_tick;

    assign w_in_range = ({1'b0, in_idx} < (N+1)'(NUM_OUT));
    // Explicit wrap against NUM_OUT-1 keeps the walk modulo NUM_OUT, not 2**N.
    assign w_at_last  = (r_cur_idx == N'(NUM_OUT - 1));
    assign w_idx_adv  = w_at_last ? '0 : r_cur_idx + N'(1);

    // Kept outside the next-state block so the timer tick never feeds back into its own run input.
    assign w_timer_load = clr || ((r_state != ST_SCAN) && scan_en);
    assign w_timer_run  = (r_state == ST_SCAN) && scan_en && !clr;

    decoder_dwell_timer #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_timer_load),
        .i_run  (w_timer_run),
        .o_tick (w_tick)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_cur_idx_next   = r_cur_idx;
        w_y_next         = r_y;
        w_y_valid_next   = r_y_valid;
        w_scan_wrap_next = 1'b0;
`ifdef DECODER_SEQ_RANGE_ERR_EN
        w_range_err_next = 1'b0;
`endif
        if (clr) begin
            w_state_next   = ST_IDLE;
            w_cur_idx_next = '0;
            w_y_next       = '0;
            w_y_valid_next = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_ACTIVE: begin
                    if (scan_en) begin
                        w_state_next   = ST_SCAN;
                        w_y_valid_next = 1'b1;
                        if (r_state == ST_IDLE) begin
                            w_cur_idx_next = '0;
                            w_y_next       = NUM_OUT'(onehot(0));
                        end
                    end else if (in_valid) begin
                        if (w_in_range) begin
                            w_state_next   = ST_ACTIVE;
                            w_cur_idx_next = in_idx;
                            w_y_next       = NUM_OUT'(onehot(32'(in_idx)));
                            w_y_valid_next = 1'b1;
                        end else begin
`ifdef DECODER_SEQ_RANGE_ERR_EN
                            w_range_err_next = 1'b1;
`else
                            w_state_next   = ST_IDLE;
                            w_cur_idx_next = '0;
                            w_y_next       = '0;
                            w_y_valid_next = 1'b0;
`endif
                        end
                    end
                end
                ST_SCAN: begin
                    if (!scan_en) begin
                        w_state_next = ST_ACTIVE;
                    end else if (w_tick) begin
                        w_cur_idx_next   = w_idx_adv;
                        w_y_next         = NUM_OUT'(onehot(32'(w_idx_adv)));
                        w_scan_wrap_next = w_at_last;
                    end
                end
                default: begin
                    w_state_next   = ST_IDLE;
                    w_cur_idx_next = '0;
                    w_y_next       = '0;
                    w_y_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur_idx   <= '0;
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_scan_wrap <= 1'b0;
`ifdef DECODER_SEQ_RANGE_ERR_EN
            r_range_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cur_idx   <= w_cur_idx_next;
            r_y         <= w_y_next;
            r_y_valid   <= w_y_valid_next;
            r_scan_wrap <= w_scan_wrap_next;
`ifdef DECODER_SEQ_RANGE_ERR_EN
            r_range_err <= w_range_err_next;
`endif
        end
    end

    assign in_ready  = (r_state != ST_SCAN);
    assign y         = r_y;
    assign y_valid   = r_y_valid;
    assign scan_wrap = r_scan_wrap;
`ifdef DECODER_SEQ_RANGE_ERR_EN
    assign range_err = r_range_err;
`else
    assign range_err = 1'b0;
`endif

endmodule
